button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 14 +
 rtl/button_channel.sv | 128 ++++++++++++
 rtl/button_conditioner.sv | 36 +++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    REL,
    HOLD_DLY,
    HOLD_RPT
  } rpt_state_t;

  localparam int DEF_DEB_CYCLES    = 50000;
  localparam int DEF_REPEAT_DELAY  = 25000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: synchronizer, debounce, press/release pulses and,
// when BTN_AUTOREPEAT_EN is defined, the auto-repeat state machine.
module button_channel
  import button_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic rpt
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          s;
  logic [DW-1:0] dcnt;
  logic          toggle;
  logic          rise;
  logic          fall;

  assign s      = ~sync2;
  assign toggle = (s != level) && (dcnt == DEB_LAST);
  assign rise   = toggle & ~level;
  assign fall   = toggle & level;

  // Synchronizer idles at 1 so a held button after reset must re-qualify.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt          <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= rise;
      release_pulse <= fall;
      if (toggle) begin
        level <= ~level;
        dcnt  <= '0;
      end else if (s == level) begin
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  rpt_state_t    state;
  rpt_state_t    state_next;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_next;
  logic          rpt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REL;
      rcnt  <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
      rpt   <= rpt_next;
    end
  end

  // A release always wins, so rpt can never land on the release cycle.
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt + 1'b1;
    rpt_next   = 1'b0;
    if (fall) begin
      state_next = REL;
      rcnt_next  = '0;
    end else begin
      case (state)
        REL: begin
          rcnt_next = '0;
          if (rise) state_next = HOLD_DLY;
        end
        HOLD_DLY: begin
          if (rcnt == DLY_LAST) begin
            state_next = HOLD_RPT;
            rcnt_next  = '0;
            rpt_next   = 1'b1;
          end
        end
        HOLD_RPT: begin
          if (rcnt == PER_LAST) begin
            rcnt_next = '0;
            rpt_next  = 1'b1;
          end
        end
        default: begin
          state_next = REL;
          rcnt_next  = '0;
        end
      endcase
    end
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// N_CH independent debounced push-button channels; auto-repeat via BTN_AUTOREPEAT_EN.
// "release" is a reserved word, so the release pulse port is release_pulse.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_n,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] rpt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_n        (btn_n[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .rpt          (rpt[i])
    );
  end

endmodule
